// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter fetch unit.
package pc_pkg;

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } pc_state_e;

  localparam int unsigned DefaultStep         = 4;
  localparam logic [31:0] DefaultResetVector  = 32'h0000_0000;
  localparam int unsigned AlignBits           = 2;
  localparam logic [AlignBits-1:0] AlignMask  = '1;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC / next-state priority mux for pc_fetch_unit.
// PC_MISALIGN_CHK_EN: misaligned branch targets divert to the trap vector and flag misalign.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = DefaultStep
) (
  input  pc_state_e       state_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            stall_i,
  input  logic            halt_i,
  input  logic            resume_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_target_i,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] next_pc_o,
  output pc_state_e       next_state_o,
  output logic            misalign_o
);

  localparam logic [XLEN-1:0] LowMask = XLEN'(AlignMask);

  logic [XLEN-1:0] trap_al;
  logic [XLEN-1:0] branch_al;
  logic            branch_mis;

  assign trap_al    = trap_target_i & ~LowMask;
  assign branch_al  = branch_target_i & ~LowMask;
  assign branch_mis = |branch_target_i[AlignBits-1:0];

  always_comb begin
    next_pc_o    = pc_i;
    next_state_o = state_i;
    misalign_o   = 1'b0;
    unique case (state_i)
      StBoot: begin
        next_state_o = StRun;
        if (trap_i) next_pc_o = trap_al;
      end
      StRun: begin
        if (trap_i) begin
          next_pc_o = trap_al;
        end else if (branch_taken_i) begin
`ifdef PC_MISALIGN_CHK_EN
          if (branch_mis) begin
            next_pc_o  = trap_al;
            misalign_o = 1'b1;
          end else begin
            next_pc_o = branch_al;
          end
`else
          next_pc_o = branch_al;
`endif
        end else if (halt_i) begin
          next_state_o = StHalted;
        end else if (!stall_i && fetch_ready_i) begin
          next_pc_o = pc_i + XLEN'(STEP);
        end
      end
      StHalted: begin
        if (trap_i) begin
          next_pc_o    = trap_al;
          next_state_o = StRun;
        end else if (resume_i) begin
          next_state_o = StRun;
        end
      end
      default: next_state_o = StBoot;
    endcase
  end

  // Only meaningful when the misalign check is built in.
  logic unused_mis;
  assign unused_mis = branch_mis;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter unit: PC register, BOOT/RUN/HALTED FSM, fetch handshake and fetch counter.
// PC_MISALIGN_CHK_EN enables misaligned-branch diversion (see pc_next_sel).
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DefaultResetVector),
  parameter int unsigned     STEP         = DefaultStep,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall_i,
  input  logic             halt_i,
  input  logic             resume_i,
  input  logic             branch_taken_i,
  input  logic [XLEN-1:0]  branch_target_i,
  input  logic             trap_i,
  input  logic [XLEN-1:0]  trap_target_i,
  input  logic             fetch_ready_i,
  output logic             fetch_valid_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc_plus_step_o,
  output logic [CNT_W-1:0] fetch_count_o,
  output logic             misalign_o
);

  pc_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q;
  logic             mis_q, mis_d;
  logic             accept;

  pc_next_sel #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_next_sel (
    .state_i         (state_q),
    .pc_i            (pc_q),
    .stall_i         (stall_i),
    .halt_i          (halt_i),
    .resume_i        (resume_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .trap_i          (trap_i),
    .trap_target_i   (trap_target_i),
    .fetch_ready_i   (fetch_ready_i),
    .next_pc_o       (pc_d),
    .next_state_o    (state_d),
    .misalign_o      (mis_d)
  );

  // Redirect cycles still count when imem accepted the (cancelled) fetch.
  assign accept = valid_q && fetch_ready_i && !stall_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= (state_d == StRun);
      mis_q   <= mis_d;
      if (accept) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign fetch_valid_o  = valid_q;
  assign pc_o           = pc_q;
  assign pc_plus_step_o = pc_q + XLEN'(STEP);
  assign fetch_count_o  = cnt_q;
  assign misalign_o     = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus queues expected state, a monitor pops and compares.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_i, halt_i, resume_i, branch_taken_i, trap_i, fetch_ready_i;
  logic [31:0] branch_target_i, trap_target_i;
  logic        fetch_valid_o, misalign_o;
  logic [31:0] pc_o, pc_plus_step_o, fetch_count_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] cnt;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];

`ifdef PC_MISALIGN_CHK_EN
  localparam logic [31:0] MisPc  = 32'h0000_0080;
  localparam logic        MisBit = 1'b1;
  localparam logic [31:0] MisNxt = 32'h0000_0084;
`else
  localparam logic [31:0] MisPc  = 32'h0000_0100;
  localparam logic        MisBit = 1'b0;
  localparam logic [31:0] MisNxt = 32'h0000_0104;
`endif

  pc_fetch_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stall_i         (stall_i),
    .halt_i          (halt_i),
    .resume_i        (resume_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .trap_i          (trap_i),
    .trap_target_i   (trap_target_i),
    .fetch_ready_i   (fetch_ready_i),
    .fetch_valid_o   (fetch_valid_o),
    .pc_o            (pc_o),
    .pc_plus_step_o  (pc_plus_step_o),
    .fetch_count_o   (fetch_count_o),
    .misalign_o      (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic expect_next(input string nm, input logic [31:0] pc, input logic v,
                             input logic [31:0] c, input logic m);
    exp_t e;
    e.name = nm; e.pc = pc; e.valid = v; e.cnt = c; e.mis = m;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs change on clock edges and on asynchronous reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge reset_n);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (pc_o !== e.pc || pc_plus_step_o !== e.pc + 32'd4 || fetch_valid_o !== e.valid ||
            fetch_count_o !== e.cnt || misalign_o !== e.mis) begin
          failures++;
          $display("FAIL %s: got pc=%h pc4=%h valid=%b cnt=%0d mis=%b, want pc=%h pc4=%h valid=%b cnt=%0d mis=%b",
                   e.name, pc_o, pc_plus_step_o, fetch_valid_o, fetch_count_o, misalign_o,
                   e.pc, e.pc + 32'd4, e.valid, e.cnt, e.mis);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    stall_i = 0; halt_i = 0; resume_i = 0; branch_taken_i = 0; trap_i = 0;
    fetch_ready_i = 1; branch_target_i = '0; trap_target_i = '0;

    @(negedge clk); expect_next("reset0", 32'h0, 0, 0, 0);
    @(negedge clk); expect_next("reset1", 32'h0, 0, 0, 0);
    @(negedge clk); reset_n = 1'b1; expect_next("boot_to_run", 32'h0, 1, 0, 0);
    @(negedge clk); expect_next("seq_4", 32'h4, 1, 1, 0);
    @(negedge clk); expect_next("seq_8", 32'h8, 1, 2, 0);
    @(negedge clk); expect_next("seq_c", 32'hc, 1, 3, 0);
    @(negedge clk); expect_next("seq_10", 32'h10, 1, 4, 0);

    // imem back-pressure
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); fetch_ready_i = 0; expect_next("not_ready_hold", 32'h10, 1, 4, 0);
    end
    @(negedge clk); fetch_ready_i = 1; expect_next("ready_again", 32'h14, 1, 5, 0);

    // redirects override stall
    @(negedge clk); stall_i = 1; branch_taken_i = 1; branch_target_i = 32'h200;
    expect_next("branch_over_stall", 32'h200, 1, 5, 0);
    @(negedge clk); trap_i = 1; trap_target_i = 32'h80;
    expect_next("trap_over_branch", 32'h80, 1, 5, 0);
    @(negedge clk); stall_i = 0; trap_i = 0; branch_target_i = 32'h102;
    expect_next("misaligned_branch", MisPc, 1, 6, MisBit);
    @(negedge clk); branch_taken_i = 0; expect_next("after_misalign", MisNxt, 1, 7, 0);

    // wrap-around
    @(negedge clk); branch_taken_i = 1; branch_target_i = 32'hFFFF_FFFC;
    expect_next("to_top", 32'hFFFF_FFFC, 1, 8, 0);
    @(negedge clk); branch_taken_i = 0; expect_next("wrap", 32'h0, 1, 9, 0);

    // halt / resume
    @(negedge clk); branch_taken_i = 1; branch_target_i = 32'h40;
    expect_next("to_40", 32'h40, 1, 10, 0);
    @(negedge clk); branch_taken_i = 0; halt_i = 1; expect_next("halt", 32'h40, 0, 11, 0);
    @(negedge clk); halt_i = 0; branch_taken_i = 1; branch_target_i = 32'h300;
    expect_next("halted_br1", 32'h40, 0, 11, 0);
    @(negedge clk); branch_taken_i = 0; expect_next("halted_br0", 32'h40, 0, 11, 0);
    @(negedge clk); branch_taken_i = 1; stall_i = 1; expect_next("halted_br_stall", 32'h40, 0, 11, 0);
    @(negedge clk); branch_taken_i = 0; stall_i = 0; resume_i = 1;
    expect_next("resume", 32'h40, 1, 11, 0);
    @(negedge clk); resume_i = 0; expect_next("after_resume", 32'h44, 1, 12, 0);
    @(negedge clk); halt_i = 1; expect_next("halt2", 32'h44, 0, 13, 0);
    @(negedge clk); halt_i = 0; trap_i = 1; resume_i = 1; trap_target_i = 32'h80;
    expect_next("halted_trap_wins", 32'h80, 1, 13, 0);
    @(negedge clk); trap_i = 0; resume_i = 0; expect_next("after_halted_trap", 32'h84, 1, 14, 0);

    // trap target low bits cleared
    @(negedge clk); trap_i = 1; trap_target_i = 32'h93; expect_next("trap_align", 32'h90, 1, 15, 0);

    // asynchronous reset mid-redirect, then trap honoured in BOOT
    @(negedge clk); trap_i = 0; branch_taken_i = 1; branch_target_i = 32'h500;
    expect_next("async_reset", 32'h0, 0, 0, 0);
    #2 reset_n = 1'b0;
    @(negedge clk); branch_taken_i = 0; expect_next("reset_hold", 32'h0, 0, 0, 0);
    @(negedge clk); reset_n = 1'b1; trap_i = 1; trap_target_i = 32'h80;
    expect_next("boot_trap", 32'h80, 1, 0, 0);
    @(negedge clk); trap_i = 0; expect_next("after_boot_trap", 32'h84, 1, 1, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
